// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared constants, FSM encodings and helpers for the AXI4 SRAM slave
//
// Purpose: response codes, read/write FSM state types and the byte-lane count
//          helper used by axi4_sram_slave and axi4_sram_array.
// Ports:   none (package).
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi4_sram_slave_if.sv
// rtl/axi4_sram_slave_if.sv - AXI4 read/write channel bundle between master and SRAM slave
//
// Purpose: groups the AR, AW, R, W and B channel signals.
// Ports:   none; modport master drives requests/write data and accepts responses,
//          modport slave is the mirror image.
interface axi4_sram_slave_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [BUS_WIDTH-1:0]    ar_addr;
  logic [2:0]              ar_prot;

  logic                    aw_valid;
  logic                    aw_ready;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [BUS_WIDTH-1:0]    aw_addr;
  logic [2:0]              aw_prot;

  logic                    rd_valid;
  logic                    rd_ready;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [ID_WIDTH-1:0]     rd_id;
  logic [1:0]              rd_resp;
  logic                    rd_last;

  logic                    wd_valid;
  logic                    wd_ready;
  logic [DATA_WIDTH-1:0]   wd_data;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wd_last;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [ID_WIDTH-1:0]     wr_id;
  logic [1:0]              wr_breap;

  modport master (
    output ar_valid, ar_id, ar_len, ar_size, ar_addr, ar_prot,
    input  ar_ready,
    output aw_valid, aw_id, aw_len, aw_size, aw_addr, aw_prot,
    input  aw_ready,
    input  rd_valid, rd_data, rd_id, rd_resp, rd_last,
    output rd_ready,
    output wd_valid, wd_data, wstrb, wd_last,
    input  wd_ready,
    input  wr_valid, wr_id, wr_breap,
    output wr_ready
  );

  modport slave (
    input  ar_valid, ar_id, ar_len, ar_size, ar_addr, ar_prot,
    output ar_ready,
    input  aw_valid, aw_id, aw_len, aw_size, aw_addr, aw_prot,
    output aw_ready,
    output rd_valid, rd_data, rd_id, rd_resp, rd_last,
    input  rd_ready,
    input  wd_valid, wd_data, wstrb, wd_last,
    output wd_ready,
    output wr_valid, wr_id, wr_breap,
    input  wr_ready
  );

endinterface

// File: rtl/axi4_sram_array.sv
// rtl/axi4_sram_array.sv - flop-array word memory with byte-enable write and async read
//
// Purpose: MEM_DEPTH words of DATA_WIDTH bits; never cleared by reset.
// Ports:   aclk     - clock
//          i_we     - write enable
//          i_waddr  - write word index
//          i_be     - per-byte write enables
//          i_wdata  - write data
//          i_raddr  - read word index
//          o_rdata  - read data (combinational, reflects writes from the next cycle)
module axi4_sram_array
  import axi4_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          i_we,
  input  logic [$clog2(MEM_DEPTH)-1:0]  i_waddr,
  input  logic [DATA_WIDTH/8-1:0]       i_be,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  input  logic [$clog2(MEM_DEPTH)-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0]         o_rdata
);

  localparam int LANES = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge aclk) begin
    if (i_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (i_be[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi4_sram_slave.sv
// rtl/axi4_sram_slave.sv - AXI4 INCR-burst responder backed by an on-chip word SRAM
//
// Purpose: independent read and write FSMs serving INCR bursts with byte strobes,
//          OKAY/SLVERR responses and range/size checking.
// Ports:   aclk  - clock, rising edge
//          reset - synchronous active-high reset (memory contents survive)
//          bus   - axi4_sram_slave_if.slave: AR/AW address, R data, W data, B response
module axi4_sram_slave
  import axi4_pkg::*;
#(
  parameter int                   BUS_WIDTH  = 32,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ID_WIDTH   = 4,
  parameter int                   MEM_DEPTH  = 1024,
  parameter logic [BUS_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic               aclk,
  input logic               reset,
  axi4_sram_slave_if.slave  bus
);

  localparam int                   LANES     = lane_count(DATA_WIDTH);
  localparam int                   LANE_BITS = $clog2(LANES);
  localparam int                   IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [BUS_WIDTH-1:0] SPAN      = BUS_WIDTH'(MEM_DEPTH * LANES);

  // The offset subtraction wraps below BASE_ADDR, so one unsigned compare covers both bounds.
  function automatic logic in_range(input logic [BUS_WIDTH-1:0] a);
    logic [BUS_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [BUS_WIDTH-1:0] a);
    logic [BUS_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> LANE_BITS);
  endfunction

  function automatic logic size_bad(input logic [2:0] sz);
    return sz > 3'(LANE_BITS);
  endfunction

  // ---------------- read channel ----------------
  rstate_t               r_rstate, w_rstate_next;
  logic [BUS_WIDTH-1:0]  r_raddr;
  logic [2:0]            r_rsize;
  logic [7:0]            r_rlen;
  logic [7:0]            r_rcount;
  logic                  r_rerr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [ID_WIDTH-1:0]   r_rd_id;
  logic [1:0]            r_rd_resp;
  logic                  r_rd_last;

  logic                  w_ar_hs;
  logic                  w_rd_hs;
  logic [BUS_WIDTH:0]    w_rnext_full;
  logic [BUS_WIDTH-1:0]  w_rnext_addr;
  logic [BUS_WIDTH-1:0]  w_rlook_addr;
  logic                  w_rlook_err;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  always_comb begin
    w_ar_hs      = bus.ar_valid && (r_rstate == R_IDLE);
    w_rd_hs      = bus.rd_ready && (r_rstate == R_DATA);
    w_rnext_full = {1'b0, r_raddr} + ((BUS_WIDTH+1)'(1) << r_rsize);
    w_rnext_addr = w_rnext_full[BUS_WIDTH-1:0];
    // The single read port looks up whichever beat will be presented next:
    // the first beat while idle, the following beat while streaming.
    if (r_rstate == R_IDLE) begin
      w_rlook_addr = bus.ar_addr;
      w_rlook_err  = size_bad(bus.ar_size) || !in_range(bus.ar_addr);
    end else begin
      w_rlook_addr = w_rnext_addr;
      w_rlook_err  = r_rerr || w_rnext_full[BUS_WIDTH] || !in_range(w_rnext_addr);
    end
  end

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_next = R_DATA;
      R_DATA:  if (w_rd_hs && r_rd_last) w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_next;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_raddr   <= '0;
      r_rsize   <= '0;
      r_rlen    <= '0;
      r_rcount  <= '0;
      r_rerr    <= 1'b0;
      r_rd_data <= '0;
      r_rd_id   <= '0;
      r_rd_resp <= RESP_OKAY;
      r_rd_last <= 1'b0;
    end else if (w_ar_hs) begin
      r_raddr   <= bus.ar_addr;
      r_rsize   <= bus.ar_size;
      r_rlen    <= bus.ar_len;
      r_rcount  <= '0;
      r_rerr    <= w_rlook_err;
      r_rd_id   <= bus.ar_id;
      r_rd_data <= w_rlook_err ? '0 : w_mem_rdata;
      r_rd_resp <= w_rlook_err ? RESP_SLVERR : RESP_OKAY;
      r_rd_last <= (bus.ar_len == 8'd0);
    end else if (w_rd_hs) begin
      if (r_rd_last) begin
        r_rd_data <= '0;
        r_rd_last <= 1'b0;
      end else begin
        r_raddr   <= w_rnext_addr;
        r_rcount  <= r_rcount + 8'd1;
        r_rerr    <= w_rlook_err;
        r_rd_data <= w_rlook_err ? '0 : w_mem_rdata;
        r_rd_resp <= w_rlook_err ? RESP_SLVERR : RESP_OKAY;
        r_rd_last <= ((r_rcount + 8'd1) == r_rlen);
      end
    end
  end

  assign bus.ar_ready = (r_rstate == R_IDLE);
  assign bus.rd_valid = (r_rstate == R_DATA);
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_id    = r_rd_id;
  assign bus.rd_resp  = r_rd_resp;
  assign bus.rd_last  = r_rd_last;

  // ---------------- write channel ----------------
  wstate_t               r_wstate, w_wstate_next;
  logic [BUS_WIDTH-1:0]  r_waddr;
  logic [2:0]            r_wsize;
  logic [7:0]            r_wlen;
  logic [7:0]            r_wcount;
  logic                  r_werr;
  logic                  r_wmis;
  logic [ID_WIDTH-1:0]   r_wr_id;
  logic [1:0]            r_wr_resp;

  logic                  w_aw_hs;
  logic                  w_wd_hs;
  logic                  w_wr_hs;
  logic                  w_wbeat_last;
  logic                  w_wmis_now;
  logic [BUS_WIDTH:0]    w_wnext_full;
  logic                  w_we;

  always_comb begin
    w_aw_hs      = bus.aw_valid && (r_wstate == W_IDLE);
    w_wd_hs      = bus.wd_valid && (r_wstate == W_DATA);
    w_wr_hs      = bus.wr_ready && (r_wstate == W_RESP);
    w_wbeat_last = (r_wcount == r_wlen);
    w_wmis_now   = (bus.wd_last != w_wbeat_last);
    w_wnext_full = {1'b0, r_waddr} + ((BUS_WIDTH+1)'(1) << r_wsize);
    w_we         = w_wd_hs && !r_werr;
  end

  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_next = W_DATA;
      // The burst length comes from aw_len alone; wd_last only feeds the mismatch flag.
      W_DATA:  if (w_wd_hs && w_wbeat_last) w_wstate_next = W_RESP;
      W_RESP:  if (w_wr_hs) w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_next;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_waddr   <= '0;
      r_wsize   <= '0;
      r_wlen    <= '0;
      r_wcount  <= '0;
      r_werr    <= 1'b0;
      r_wmis    <= 1'b0;
      r_wr_id   <= '0;
      r_wr_resp <= RESP_OKAY;
    end else if (w_aw_hs) begin
      r_waddr  <= bus.aw_addr;
      r_wsize  <= bus.aw_size;
      r_wlen   <= bus.aw_len;
      r_wcount <= '0;
      r_werr   <= size_bad(bus.aw_size) || !in_range(bus.aw_addr);
      r_wmis   <= 1'b0;
      r_wr_id  <= bus.aw_id;
    end else if (w_wd_hs) begin
      r_waddr  <= w_wnext_full[BUS_WIDTH-1:0];
      r_wcount <= r_wcount + 8'd1;
      r_werr   <= r_werr || w_wnext_full[BUS_WIDTH] || !in_range(w_wnext_full[BUS_WIDTH-1:0]);
      if (w_wmis_now) r_wmis <= 1'b1;
      if (w_wbeat_last) begin
        r_wr_resp <= (r_werr || r_wmis || w_wmis_now) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign bus.aw_ready = (r_wstate == W_IDLE);
  assign bus.wd_ready = (r_wstate == W_DATA);
  assign bus.wr_valid = (r_wstate == W_RESP);
  assign bus.wr_id    = r_wr_id;
  assign bus.wr_breap = r_wr_resp;

  logic w_unused;
  assign w_unused = ^{bus.ar_prot, bus.aw_prot};

  axi4_sram_array #(
    .MEM_DEPTH  (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .aclk    (aclk),
    .i_we    (w_we),
    .i_waddr (word_idx(r_waddr)),
    .i_be    (bus.wstrb),
    .i_wdata (bus.wd_data),
    .i_raddr (word_idx(w_rlook_addr)),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb/tb_axi4_sram_slave.sv - directed self-checking bench for axi4_sram_slave
module tb_axi4_sram_slave;
  import axi4_pkg::*;

  logic aclk = 1'b0;
  logic reset = 1'b1;
  always #5 aclk = ~aclk;

  axi4_sram_slave_if #(.BUS_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  axi4_sram_slave #(
    .BUS_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024), .BASE_ADDR(32'h0)
  ) dut (
    .aclk  (aclk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wdat [0:15];
  logic [3:0]  wstb [0:15];
  logic [31:0] rdat [0:255];
  logic [1:0]  rresp[0:255];
  logic        rlast[0:255];
  logic [3:0]  rid  [0:255];
  int          stall_bad;
  int          rbeats;
  logic        first_valid;
  logic [1:0]  wresp;
  logic [3:0]  wid;
  int          waccepted;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic timeout_fail(input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake did not occur within bound", what);
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [3:0] id, input int last_at);
    int to;
    bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = size; bus.aw_id = id; bus.aw_valid = 1'b1;
    to = 0;
    while (!bus.aw_ready && to < 50) begin tick(); to++; end
    if (to >= 50) timeout_fail("aw_handshake");
    tick();
    bus.aw_valid = 1'b0;
    waccepted = 0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wd_data = wdat[i]; bus.wstrb = wstb[i]; bus.wd_last = (i == last_at); bus.wd_valid = 1'b1;
      to = 0;
      while (!bus.wd_ready && to < 50) begin tick(); to++; end
      if (to >= 50) begin timeout_fail("wd_handshake"); break; end
      tick();
      waccepted++;
    end
    bus.wd_valid = 1'b0; bus.wd_last = 1'b0;
    bus.wr_ready = 1'b1;
    to = 0;
    while (!bus.wr_valid && to < 50) begin tick(); to++; end
    if (to >= 50) timeout_fail("wr_handshake");
    wresp = bus.wr_breap;
    wid   = bus.wr_id;
    tick();
    bus.wr_ready = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [3:0] id, input bit stall);
    int          to;
    int          cyc;
    bit          held_v;
    logic [31:0] held_d;
    logic        held_l;
    bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = size; bus.ar_id = id; bus.ar_valid = 1'b1;
    to = 0;
    while (!bus.ar_ready && to < 50) begin tick(); to++; end
    if (to >= 50) timeout_fail("ar_handshake");
    tick();
    bus.ar_valid = 1'b0;
    first_valid = bus.rd_valid;
    rbeats = 0; cyc = 0; held_v = 0; held_d = '0; held_l = 1'b0; stall_bad = 0;
    while (rbeats <= int'(len) && cyc < 2000) begin
      bus.rd_ready = stall ? (cyc % 2 == 1) : 1'b1;
      if (held_v) begin
        if (!bus.rd_valid || bus.rd_data !== held_d || bus.rd_last !== held_l) stall_bad++;
        held_v = 0;
      end
      if (bus.rd_valid) begin
        if (bus.rd_ready) begin
          rdat[rbeats] = bus.rd_data; rresp[rbeats] = bus.rd_resp;
          rlast[rbeats] = bus.rd_last; rid[rbeats] = bus.rd_id;
          rbeats++;
        end else begin
          held_v = 1; held_d = bus.rd_data; held_l = bus.rd_last;
        end
      end
      tick();
      cyc++;
    end
    bus.rd_ready = 1'b0;
    if (cyc >= 2000) timeout_fail("rd_beats");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_checks++; if (bus.ar_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ar_ready: got %b want 1", bus.ar_ready); end
    n_checks++; if (bus.aw_ready !== 1'b1) begin n_fail++; $display("FAIL reset_aw_ready: got %b want 1", bus.aw_ready); end
    n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    n_checks++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", bus.wr_valid); end
    n_checks++; if (bus.wd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wd_ready: got %b want 0", bus.wd_ready); end
    n_checks++; if (bus.rd_data !== 32'h0 || bus.rd_last !== 1'b0 || bus.rd_resp !== 2'b00 || bus.rd_id !== 4'h0)
      begin n_fail++; $display("FAIL reset_r_payload: data %h last %b resp %b id %h want zeros", bus.rd_data, bus.rd_last, bus.rd_resp, bus.rd_id); end
    n_checks++; if (bus.wr_breap !== 2'b00 || bus.wr_id !== 4'h0)
      begin n_fail++; $display("FAIL reset_b_payload: resp %b id %h want 00/0", bus.wr_breap, bus.wr_id); end
  endtask

  task automatic test_single();
    wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
    write_burst(32'h10, 8'd0, 3'd2, 4'd5, 0);
    n_checks++; if (wresp !== 2'b00) begin n_fail++; $display("FAIL single_wresp: got %b want 00", wresp); end
    n_checks++; if (wid !== 4'd5) begin n_fail++; $display("FAIL single_wid: got %h want 5", wid); end
    read_burst(32'h10, 8'd0, 3'd2, 4'd3, 1'b0);
    n_checks++; if (first_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: rd_valid %b want 1 after AR", first_valid); end
    n_checks++; if (rbeats != 1) begin n_fail++; $display("FAIL single_beats: got %0d want 1", rbeats); end
    n_checks++; if (rdat[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h want deadbeef", rdat[0]); end
    n_checks++; if (rlast[0] !== 1'b1 || rresp[0] !== 2'b00 || rid[0] !== 4'd3)
      begin n_fail++; $display("FAIL single_rmeta: last %b resp %b id %h want 1/00/3", rlast[0], rresp[0], rid[0]); end
    n_checks++; if (bus.ar_ready !== 1'b1 || bus.rd_valid !== 1'b0)
      begin n_fail++; $display("FAIL single_idle: ar_ready %b rd_valid %b want 1/0", bus.ar_ready, bus.rd_valid); end
  endtask

  task automatic test_burst_strobes();
    logic [31:0] exp_d [0:3];
    wdat[0] = 32'h11223344; wstb[0] = 4'hF;
    write_burst(32'h24, 8'd0, 3'd2, 4'd1, 0);
    wdat[0] = 32'h1; wdat[1] = 32'h2; wdat[2] = 32'h3; wdat[3] = 32'h4;
    wstb[0] = 4'hF; wstb[1] = 4'h1; wstb[2] = 4'hF; wstb[3] = 4'hF;
    write_burst(32'h20, 8'd3, 3'd2, 4'd7, 3);
    n_checks++; if (wresp !== 2'b00 || wid !== 4'd7) begin n_fail++; $display("FAIL burst_wresp: resp %b id %h want 00/7", wresp, wid); end
    read_burst(32'h20, 8'd3, 3'd2, 4'd9, 1'b1);
    exp_d[0] = 32'h1; exp_d[1] = 32'h11223302; exp_d[2] = 32'h3; exp_d[3] = 32'h4;
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL burst_stall_hold: %0d unstable beats want 0", stall_bad); end
    n_checks++; if (rbeats != 4) begin n_fail++; $display("FAIL burst_beats: got %0d want 4", rbeats); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rdat[i] !== exp_d[i] || rresp[i] !== 2'b00 || rlast[i] !== (i == 3))
        begin n_fail++; $display("FAIL burst_beat%0d: data %h resp %b last %b want %h/00/%b", i, rdat[i], rresp[i], rlast[i], exp_d[i], (i == 3)); end
    end
  endtask

  task automatic test_out_of_range();
    wdat[0] = 32'hCAFEF00D; wstb[0] = 4'hF;
    write_burst(32'h0, 8'd0, 3'd2, 4'd0, 0);
    read_burst(32'h1000, 8'd1, 3'd2, 4'd2, 1'b0);
    n_checks++; if (rbeats != 2) begin n_fail++; $display("FAIL oor_read_beats: got %0d want 2", rbeats); end
    n_checks++; if (rdat[0] !== 32'h0 || rdat[1] !== 32'h0 || rresp[0] !== 2'b10 || rresp[1] !== 2'b10 || rlast[1] !== 1'b1)
      begin n_fail++; $display("FAIL oor_read: data %h %h resp %b %b last %b want 0 0 10 10 1", rdat[0], rdat[1], rresp[0], rresp[1], rlast[1]); end
    wdat[0] = 32'h55555555; wstb[0] = 4'hF;
    write_burst(32'h1000, 8'd0, 3'd2, 4'd4, 0);
    n_checks++; if (wresp !== 2'b10) begin n_fail++; $display("FAIL oor_wresp: got %b want 10", wresp); end
    // Top-of-memory crossing: first beat lands in the last word, second is dropped.
    wdat[0] = 32'hA1A1A1A1; wdat[1] = 32'hB2B2B2B2; wstb[0] = 4'hF; wstb[1] = 4'hF;
    write_burst(32'hFFC, 8'd1, 3'd2, 4'd6, 1);
    n_checks++; if (wresp !== 2'b10) begin n_fail++; $display("FAIL cross_wresp: got %b want 10", wresp); end
    read_burst(32'hFFC, 8'd1, 3'd2, 4'd6, 1'b0);
    n_checks++; if (rdat[0] !== 32'hA1A1A1A1 || rresp[0] !== 2'b00 || rlast[0] !== 1'b0)
      begin n_fail++; $display("FAIL cross_beat0: data %h resp %b last %b want a1a1a1a1/00/0", rdat[0], rresp[0], rlast[0]); end
    n_checks++; if (rdat[1] !== 32'h0 || rresp[1] !== 2'b10 || rlast[1] !== 1'b1)
      begin n_fail++; $display("FAIL cross_beat1: data %h resp %b last %b want 0/10/1", rdat[1], rresp[1], rlast[1]); end
    read_burst(32'h0, 8'd0, 3'd2, 4'd0, 1'b0);
    n_checks++; if (rdat[0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL oor_no_alias: word0 %h want cafef00d", rdat[0]); end
  endtask

  task automatic test_wlast_mismatch();
    wdat[0] = 32'h10; wdat[1] = 32'h20; wdat[2] = 32'h30; wdat[3] = 32'h40;
    for (int i = 0; i < 4; i++) wstb[i] = 4'hF;
    write_burst(32'h40, 8'd3, 3'd2, 4'd8, 1);
    n_checks++; if (waccepted != 4) begin n_fail++; $display("FAIL mis_beats: got %0d want 4", waccepted); end
    n_checks++; if (wresp !== 2'b10 || wid !== 4'd8) begin n_fail++; $display("FAIL mis_wresp: resp %b id %h want 10/8", wresp, wid); end
    read_burst(32'h4C, 8'd0, 3'd2, 4'd1, 1'b0);
    n_checks++; if (rdat[0] !== 32'h40) begin n_fail++; $display("FAIL mis_last_data: got %h want 00000040", rdat[0]); end
  endtask

  task automatic test_size_error();
    read_burst(32'h10, 8'd0, 3'd3, 4'd2, 1'b0);
    n_checks++; if (rdat[0] !== 32'h0 || rresp[0] !== 2'b10)
      begin n_fail++; $display("FAIL size_err: data %h resp %b want 0/10", rdat[0], rresp[0]); end
  endtask

  task automatic test_len255();
    int bad;
    read_burst(32'h0, 8'd255, 3'd2, 4'd1, 1'b0);
    n_checks++; if (rbeats != 256) begin n_fail++; $display("FAIL len255_beats: got %0d want 256", rbeats); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (rresp[i] !== 2'b00 || rlast[i] !== (i == 255)) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL len255_meta: %0d beats with wrong resp/last want 0", bad); end
  endtask

  task automatic test_reset_mid_burst();
    int to;
    bus.ar_addr = 32'h20; bus.ar_len = 8'd7; bus.ar_size = 3'd2; bus.ar_id = 4'd3; bus.ar_valid = 1'b1;
    to = 0;
    while (!bus.ar_ready && to < 50) begin tick(); to++; end
    tick();
    bus.ar_valid = 1'b0;
    bus.rd_ready = 1'b1;
    to = 0;
    while (!bus.rd_valid && to < 50) begin tick(); to++; end
    if (to >= 50) timeout_fail("mid_first_beat");
    tick();
    bus.rd_ready = 1'b0;
    n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h11223302)
      begin n_fail++; $display("FAIL mid_beat2: valid %b data %h want 1/11223302", bus.rd_valid, bus.rd_data); end
    reset = 1'b1;
    tick();
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.ar_ready !== 1'b1)
      begin n_fail++; $display("FAIL mid_abort: rd_valid %b ar_ready %b want 0/1", bus.rd_valid, bus.ar_ready); end
    reset = 1'b0;
    tick();
    read_burst(32'h10, 8'd0, 3'd2, 4'd2, 1'b0);
    n_checks++; if (rbeats != 1 || rdat[0] !== 32'hDEADBEEF || rresp[0] !== 2'b00 || rlast[0] !== 1'b1)
      begin n_fail++; $display("FAIL mid_recover: beats %0d data %h resp %b last %b want 1/deadbeef/00/1", rbeats, rdat[0], rresp[0], rlast[0]); end
  endtask

  initial begin
    bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_addr = '0; bus.ar_prot = '0;
    bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_addr = '0; bus.aw_prot = '0;
    bus.rd_ready = 1'b0;
    bus.wd_valid = 1'b0; bus.wd_data = '0; bus.wstrb = '0; bus.wd_last = 1'b0;
    bus.wr_ready = 1'b0;
    test_reset();
    test_single();
    test_burst_strobes();
    test_out_of_range();
    test_wlast_mismatch();
    test_size_error();
    test_len255();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
AXI4 responder that terminates the core's AXI4 master port on a word-addressed on-chip SRAM modelled as a flop array. It serves INCR bursts on independent read and write channels, applies byte strobes, and returns OKAY/SLVERR responses. It is the simulation/FPGA memory endpoint for the CPU bus and the golden slave for master-side verification.

Parameters:
BUS_WIDTH, 32, address width
DATA_WIDTH, 32, data width; byte lanes = DATA_WIDTH/8
ID_WIDTH, 4, transaction ID width
MEM_DEPTH, 1024, number of DATA_WIDTH words
BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
aclk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
ar_valid  in  1  read address valid
ar_ready  out  1  read address ready
ar_id  in  ID_WIDTH  read ID
ar_len  in  8  beats-1
ar_size  in  3  log2 bytes per beat
ar_addr  in  BUS_WIDTH  start byte address
ar_prot  in  3  ignored
aw_valid  in  1  write address valid
aw_ready  out  1  write address ready
aw_id  in  ID_WIDTH  write ID
aw_len  in  8  beats-1
aw_size  in  3  log2 bytes per beat
aw_addr  in  BUS_WIDTH  start byte address
aw_prot  in  3  ignored
rd_valid  out  1  read data valid
rd_ready  in  1  read data ready
rd_data  out  DATA_WIDTH  read data
rd_id  out  ID_WIDTH  echoed ar_id
rd_resp  out  2  00 OKAY, 10 SLVERR
rd_last  out  1  final beat
wd_valid  in  1  write data valid
wd_ready  out  1  write data ready
wd_data  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wd_last  in  1  final write beat
wr_valid  out  1  write response valid
wr_ready  in  1  write response ready
wr_id  out  ID_WIDTH  echoed aw_id
wr_breap  out  2  write response, 00 OKAY, 10 SLVERR

Behaviour:
- One clock aclk; reset synchronous, active-high. On reset: ar_ready=1, aw_ready=1, wd_ready=0, rd_valid=0, rd_last=0, rd_data=0, rd_id=0, rd_resp=0, wr_valid=0, wr_id=0, wr_breap=0; both FSMs idle. Memory contents are not cleared.
- Handshake: transfer when valid&&ready on the same edge. Outputs are registered. A valid, once raised, holds with its payload until it is accepted.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ar_ready=1. An AR handshake latches id, addr, len, size and beat counter = 0, sets err, and moves to R_DATA.
  - R_DATA: rd_valid=1; rd_data = mem[word index of current addr] (0 when err); rd_last = (count == len).
  - On each beat handshake: addr += 1<<size, count++. When the accepted beat had rd_last=1, go to R_IDLE (ar_ready=1 next cycle).
  - First-beat latency: rd_valid is high the cycle after the AR handshake.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: aw_ready=1. An AW handshake latches id, addr, len, size and err, then moves to W_DATA.
  - W_DATA: wd_ready=1. Each beat writes the lanes with wstrb=1 at the word index, unless err is set. Then addr += 1<<size, count++.
  - The beat with count == len ends the burst and moves to W_RESP. If wd_last != (count == len) on any beat, a sticky mismatch flag is set. The burst still ends on the count.
  - W_RESP: wr_valid=1, wr_id = latched id, wr_breap = SLVERR if err or mismatch, else OKAY. Return to W_IDLE on the wr_ready handshake.
- err is set for a burst when size > log2(DATA_WIDTH/8) or the start address is outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*bytes). err is also set per beat if the address crosses the top of memory mid-burst; from that beat on, reads return 0/SLVERR and writes are dropped.
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Narrow transfers return the full word; the master selects lanes.
- Read and write FSMs run concurrently. A same-cycle read and write to one word returns the old data; the new data is visible from the next cycle.
- The address counter is BUS_WIDTH bits and wraps modulo 2^BUS_WIDTH. The wrapped address is out of range and gives SLVERR.
- ar_len/aw_len = 255 gives 256 beats. The beat counter is 8 bits and compares equal at 255.
- Reset mid-burst aborts both FSMs to idle with no further beats or response. Memory writes already committed stay.

Decomposition:
- Package axi4_pkg holds the RESP_OKAY/RESP_SLVERR constants, the read/write FSM state encodings, and a byte-lane count function.
- Natural sub-module: axi4_sram_array. It has one write port with byte enables, one asynchronous read port, and the MEM_DEPTH and DATA_WIDTH parameters. The FSMs live in axi4_sram_slave.

Test Plan:
- Reset then idle: ar_ready=aw_ready=1; rd_valid=wr_valid=wd_ready=0.
- Write 0xDEADBEEF to addr 0x10 (len 0, size 2, wstrb 0xF), then read 0x10 -> wr_breap=00, wr_id=aw_id; rd_data=0xDEADBEEF, rd_last=1, rd_resp=00.
- 4-beat INCR write at 0x20 of 1,2,3,4 with beat 2 wstrb=0x1, then a 4-beat read with rd_ready low on alternate cycles:
  - each beat is held stable while stalled;
  - data = 1, old[31:8]|0x02, 3, 4;
  - rd_last only on beat 4.
- Read at BASE_ADDR+MEM_DEPTH*4 (len 1) -> 2 beats, rd_data=0, rd_resp=10. A write there -> wr_breap=10 and memory is unchanged.
- Write burst len 3 with wd_last on beat 2 -> 4 beats accepted, wr_breap=10.
- Reset asserted during beat 2 of an 8-beat read -> next cycle rd_valid=0, ar_ready=1. A new read then completes normally.
